// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: prefetch FIFO of {pc, instr} pairs between fetch and decode, with one-cycle flush
module instr_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_instr,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_instr,
    output logic [5:0]       out_opcode,
    output logic [4:0]       out_rs,
    output logic [4:0]       out_rt,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_shamt,
    output logic [5:0]       out_funct,
    output logic [15:0]      out_imm16,
    output logic [25:0]      out_imm26,
    output logic [CNT_W-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    logic [31:0]      r_pc    [DEPTH];
    logic [31:0]      r_instr [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;
    assign in_ready   = r_count != CNT_W'(DEPTH);
    assign out_valid  = r_count != '0;
    assign w_push     = in_valid & in_ready;
    assign w_pop      = out_valid & out_ready;
    assign count      = r_count;
    assign out_pc     = out_valid ? r_pc[r_rd_ptr] : '0;
    assign out_instr  = out_valid ? r_instr[r_rd_ptr] : '0;
    assign out_opcode = out_instr[31:26];
    assign out_rs     = out_instr[25:21];
    assign out_rt     = out_instr[20:16];
    assign out_rd     = out_instr[15:11];
    assign out_shamt  = out_instr[10:6];
    assign out_funct  = out_instr[5:0];
    assign out_imm16  = out_instr[15:0];
    assign out_imm26  = out_instr[25:0];
    // storage write; entries survive flush/reset since count masks them
    always_ff @(posedge clk) begin
        if (reset && !flush && w_push) begin
            r_pc[r_wr_ptr]    <= in_pc;
            r_instr[r_wr_ptr] <= in_instr;
        end
    end
    // pointers and occupancy; reset beats flush, flush beats push/pop
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= w_push ? r_wr_ptr + 1'b1 : r_wr_ptr;
            r_rd_ptr <= w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
            r_count  <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end
endmodule
